// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core load/store path and a DMA burst port.
// Optional macro DMEM_ARB_PERF_EN adds saturating stall/word counters on perf_* outputs.
module dmem_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int LEN_W     = 6,
  parameter int MAX_STALL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic [31:0]       core_rdata,
  output logic              core_stall,
  input  logic              dma_start,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_base,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic [31:0]       dma_wdata,
  output logic              dma_wdata_pop,
  output logic [31:0]       dma_rdata,
  output logic              dma_rdata_valid,
  output logic              dma_busy,
  output logic              dma_done,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_Memwrite,
  output logic              mem_Memread,
  input  logic [31:0]       mem_read_data,
  output logic [15:0]       perf_core_stalls,
  output logic [15:0]       perf_dma_words
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  localparam logic [3:0] STALL_LIM = 4'(MAX_STALL);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q, idx_q;
  logic              we_q;
  logic [3:0]        stall_cnt;
  logic              dma_slot, core_gnt, last_word;
  logic [ADDR_W-1:0] dma_addr;

  // A pending burst takes any idle slot, or steals one once the core has won MAX_STALL in a row.
  assign dma_slot  = (state == BURST) && (!core_req || stall_cnt == STALL_LIM);
  assign core_gnt  = core_req && !dma_slot;
  assign dma_addr  = base_q + idx_q[ADDR_W-1:0];
  assign last_word = (idx_q == len_q - LEN_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dma_start) state_nxt = (dma_len == '0) ? DONE : BURST;
      BURST:   if (dma_slot && last_word) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      stall_cnt <= '0;
      dma_busy  <= 1'b0;
      dma_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      dma_busy <= (state_nxt == BURST);
      dma_done <= (state_nxt == DONE);
      if (state == IDLE && dma_start) begin
        base_q <= dma_base;
        len_q  <= dma_len;
        we_q   <= dma_we;
        idx_q  <= '0;
      end else if (dma_slot) begin
        idx_q <= idx_q + LEN_W'(1);
      end
      // In BURST a non-DMA cycle is always a core win, and the cap forces a slot before overflow.
      stall_cnt <= (state == BURST && !dma_slot) ? stall_cnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    mem_address     = '0;
    mem_write_data  = '0;
    mem_Memwrite    = 1'b0;
    mem_Memread     = 1'b0;
    core_rdata      = '0;
    dma_rdata       = '0;
    dma_rdata_valid = 1'b0;
    dma_wdata_pop   = 1'b0;
    core_stall      = core_req && dma_slot;
    if (core_gnt) begin
      mem_address    = 32'(core_addr);
      mem_write_data = core_wdata;
      mem_Memwrite   = core_we;
      mem_Memread    = !core_we;
      core_rdata     = mem_read_data;
    end else if (dma_slot) begin
      mem_address    = 32'(dma_addr);
      mem_write_data = dma_wdata;
      mem_Memwrite   = we_q;
      mem_Memread    = !we_q;
      dma_wdata_pop  = we_q;
      if (!we_q) begin
        dma_rdata       = mem_read_data;
        dma_rdata_valid = 1'b1;
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_core_stalls <= '0;
      perf_dma_words   <= '0;
    end else begin
      if (core_stall && perf_core_stalls != 16'hFFFF) perf_core_stalls <= perf_core_stalls + 16'd1;
      if (dma_slot && perf_dma_words != 16'hFFFF)     perf_dma_words   <= perf_dma_words + 16'd1;
    end
  end
`else
  assign perf_core_stalls = 16'h0000;
  assign perf_dma_words   = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a cycle-level
// reference model; a behavioural 32-word memory sits on the mem_* pins.
module tb_dmem_arbiter;
  localparam int MS = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        core_req = 0, core_we = 0;
  logic [4:0]  core_addr = 0;
  logic [31:0] core_wdata = 0, core_rdata;
  logic        core_stall;
  logic        dma_start = 0, dma_we = 0;
  logic [4:0]  dma_base = 0;
  logic [5:0]  dma_len = 0;
  logic [31:0] dma_wdata = 0, dma_rdata;
  logic        dma_wdata_pop, dma_rdata_valid, dma_busy, dma_done;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_Memwrite, mem_Memread;
  logic [15:0] perf_core_stalls, perf_dma_words;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  int nvec = 0, nerr = 0;

  dmem_arbiter #(.ADDR_W(5), .LEN_W(6), .MAX_STALL(MS)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_start(dma_start), .dma_we(dma_we), .dma_base(dma_base), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_wdata_pop(dma_wdata_pop), .dma_rdata(dma_rdata),
    .dma_rdata_valid(dma_rdata_valid), .dma_busy(dma_busy), .dma_done(dma_done),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_Memwrite(mem_Memwrite), .mem_Memread(mem_Memread), .mem_read_data(mem_read_data),
    .perf_core_stalls(perf_core_stalls), .perf_dma_words(perf_dma_words)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_Memwrite) mem[mem_address[4:0]] <= mem_write_data;
  assign mem_read_data = mem[mem_address[4:0]];

  task automatic idle_in();
    core_req = 0; core_we = 0; dma_start = 0; dma_we = 0; dma_len = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst();
    rst = 1; step(); rst = 0;
  endtask

  task automatic test_reset();
    idle_in(); rst = 1;
    @(negedge clk);
    nvec++; if (dma_busy !== 0 || dma_done !== 0) begin nerr++; $display("FAIL reset_flags busy=%b done=%b want 0/0", dma_busy, dma_done); end
    nvec++; if (mem_Memwrite !== 0 || mem_Memread !== 0 || mem_address !== 0) begin nerr++; $display("FAIL reset_mem we=%b rd=%b addr=%h want 0", mem_Memwrite, mem_Memread, mem_address); end
    nvec++; if (core_stall !== 0 || perf_core_stalls !== 0 || perf_dma_words !== 0) begin nerr++; $display("FAIL reset_misc stall=%b perf=%h/%h want 0", core_stall, perf_core_stalls, perf_dma_words); end
    step(); rst = 0;
  endtask

  task automatic test_core();
    core_req = 1; core_we = 1; core_addr = 3; core_wdata = 32'hDEADBEEF;
    @(negedge clk);
    nvec++; if (core_stall !== 0 || mem_Memwrite !== 1 || mem_address !== 3) begin nerr++; $display("FAIL core_store stall=%b we=%b addr=%h want 0/1/3", core_stall, mem_Memwrite, mem_address); end
    step(); core_we = 0;
    @(negedge clk);
    nvec++; if (core_rdata !== 32'hDEADBEEF || core_stall !== 0 || dma_busy !== 0) begin nerr++; $display("FAIL core_load rdata=%h stall=%b busy=%b want deadbeef/0/0", core_rdata, core_stall, dma_busy); end
    step();
    for (int i = 0; i < 32; i++) begin
      core_we = 1; core_addr = 5'(i); core_wdata = $urandom; ref_mem[i] = core_wdata; step();
    end
    for (int i = 0; i < 24; i++) begin
      core_we = 0; core_addr = 5'($urandom_range(0, 31));
      @(negedge clk);
      nvec++; if (core_rdata !== ref_mem[core_addr] || core_stall !== 0) begin nerr++; $display("FAIL core_rand_load a=%0d got=%h want=%h", core_addr, core_rdata, ref_mem[core_addr]); end
      step();
    end
    idle_in();
  endtask

  task automatic test_dma_write();
    int pops = 0, busy_n = 0, done_c = 0;
    bit p;
    dma_start = 1; dma_we = 1; dma_base = 30; dma_len = 4; dma_wdata = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      p = dma_wdata_pop;
      if (p) pops++;
      if (dma_busy) busy_n++;
      if (dma_done && done_c == 0) done_c = c;
      step(); dma_start = 0;
      if (p) dma_wdata = dma_wdata + 1;
    end
    nvec++; if (pops != 4 || busy_n != 4) begin nerr++; $display("FAIL dma_wr_pops pops=%0d busy=%0d want 4/4", pops, busy_n); end
    nvec++; if (done_c != 6) begin nerr++; $display("FAIL dma_wr_done cycle=%0d want 6", done_c); end
    nvec++; if (mem[30] !== 1 || mem[31] !== 2 || mem[0] !== 3 || mem[1] !== 4) begin nerr++; $display("FAIL dma_wr_wrap got %0d %0d %0d %0d want 1 2 3 4", mem[30], mem[31], mem[0], mem[1]); end
    ref_mem[30] = 1; ref_mem[31] = 2; ref_mem[0] = 3; ref_mem[1] = 4;
    idle_in();
  endtask

  task automatic test_starve();
    int b, nrd = 0, done_c = 0;
    bit exp_slot;
    pulse_rst();
    b = $urandom_range(0, 31);
    core_req = 1; core_we = 0;
    dma_start = 1; dma_we = 0; dma_base = 5'(b); dma_len = 2;
    for (int c = 1; c <= 2 * MS + 6; c++) begin
      core_addr = 5'($urandom_range(0, 31));
      exp_slot = (c == MS + 2) || (c == 2 * MS + 3);
      @(negedge clk);
      nvec++; if (core_stall !== exp_slot || dma_rdata_valid !== exp_slot) begin nerr++; $display("FAIL starve_slot c=%0d stall=%b valid=%b want %b", c, core_stall, dma_rdata_valid, exp_slot); end
      if (exp_slot) begin
        nvec++; if (dma_rdata !== ref_mem[(b + nrd) % 32]) begin nerr++; $display("FAIL starve_rdata c=%0d got=%h want=%h", c, dma_rdata, ref_mem[(b + nrd) % 32]); end
        nrd++;
      end else if (dma_done === 0) begin
        nvec++; if (core_rdata !== ref_mem[core_addr]) begin nerr++; $display("FAIL starve_core c=%0d got=%h want=%h", c, core_rdata, ref_mem[core_addr]); end
      end
      if (dma_done && done_c == 0) done_c = c;
      step(); dma_start = 0;
    end
    nvec++; if (done_c != 2 * MS + 4) begin nerr++; $display("FAIL starve_done cycle=%0d want %0d", done_c, 2 * MS + 4); end
`ifdef DMEM_ARB_PERF_EN
    nvec++; if (perf_core_stalls !== 2 || perf_dma_words !== 2) begin nerr++; $display("FAIL perf stalls=%0d words=%0d want 2/2", perf_core_stalls, perf_dma_words); end
`else
    nvec++; if (perf_core_stalls !== 0 || perf_dma_words !== 0) begin nerr++; $display("FAIL perf stalls=%0d words=%0d want 0/0", perf_core_stalls, perf_dma_words); end
`endif
    idle_in();
  endtask

  task automatic test_len0();
    int done_n = 0, done_c = 0;
    bit bad = 0;
    dma_start = 1; dma_we = 1; dma_len = 0; dma_base = 7;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (mem_Memwrite || mem_Memread || dma_busy) bad = 1;
      if (dma_done) begin done_n++; if (done_c == 0) done_c = c; end
      step(); dma_start = 0;
    end
    nvec++; if (bad) begin nerr++; $display("FAIL len0_access got activity want none"); end
    nvec++; if (done_n != 1 || done_c != 2) begin nerr++; $display("FAIL len0_done n=%0d cycle=%0d want 1/2", done_n, done_c); end
    idle_in();
  endtask

  task automatic test_reset_mid();
    int b;
    bit bad = 0;
    b = $urandom_range(0, 31);
    dma_start = 1; dma_we = 1; dma_base = 5'(b); dma_len = 8; dma_wdata = 32'hA5A50000;
    step(); dma_start = 0;
    step(); dma_wdata = 32'hA5A50001;
    rst = 1;
    @(negedge clk);
    nvec++; if (dma_busy !== 0 || dma_done !== 0 || mem_Memwrite !== 0) begin nerr++; $display("FAIL rstmid_abort busy=%b done=%b we=%b want 0", dma_busy, dma_done, mem_Memwrite); end
    step(); rst = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (dma_busy || dma_done || mem_Memwrite) bad = 1;
      step();
    end
    nvec++; if (bad) begin nerr++; $display("FAIL rstmid_after got activity want none"); end
    nvec++; if (mem[b] !== 32'hA5A50000) begin nerr++; $display("FAIL rstmid_word0 got=%h want a5a50000", mem[b]); end
    ref_mem[b] = 32'hA5A50000;
    for (int i = 1; i < 8; i++) begin
      nvec++; if (mem[(b + i) % 32] !== ref_mem[(b + i) % 32]) begin nerr++; $display("FAIL rstmid_word%0d got=%h want=%h", i, mem[(b + i) % 32], ref_mem[(b + i) % 32]); end
    end
  endtask

  task automatic test_random();
    bit m_busy = 0, m_done = 0, m_we = 0, e_slot, e_core;
    int m_base = 0, m_len = 0, m_idx = 0, m_cnt = 0, a;
    pulse_rst();
    for (int c = 0; c < 600; c++) begin
      core_req = ($urandom_range(0, 99) < 60); core_we = $urandom_range(0, 1);
      core_addr = 5'($urandom); core_wdata = $urandom; dma_wdata = $urandom;
      dma_start = ($urandom_range(0, 7) == 0); dma_we = $urandom_range(0, 1);
      dma_base = 5'($urandom); dma_len = 6'($urandom_range(0, 32));
      e_slot = m_busy && (!core_req || m_cnt == MS);
      e_core = core_req && !e_slot;
      a = (m_base + m_idx) % 32;
      @(negedge clk);
      nvec++; if (core_stall !== (core_req && e_slot) || dma_busy !== m_busy || dma_done !== m_done) begin nerr++; $display("FAIL rand_ctl c=%0d stall=%b busy=%b done=%b want %b/%b/%b", c, core_stall, dma_busy, dma_done, core_req && e_slot, m_busy, m_done); end
      nvec++; if (dma_wdata_pop !== (e_slot && m_we) || dma_rdata_valid !== (e_slot && !m_we)) begin nerr++; $display("FAIL rand_dir c=%0d pop=%b valid=%b", c, dma_wdata_pop, dma_rdata_valid); end
      if (e_slot && !m_we) begin
        nvec++; if (dma_rdata !== ref_mem[a]) begin nerr++; $display("FAIL rand_rdata c=%0d got=%h want=%h", c, dma_rdata, ref_mem[a]); end
      end
      if (e_core && !core_we) begin
        nvec++; if (core_rdata !== ref_mem[core_addr]) begin nerr++; $display("FAIL rand_load c=%0d got=%h want=%h", c, core_rdata, ref_mem[core_addr]); end
      end
      if (e_core && core_we) ref_mem[core_addr] = core_wdata;
      if (e_slot && m_we) ref_mem[a] = dma_wdata;
      if (m_done) m_done = 0;
      else if (m_busy) begin
        if (e_slot) begin
          m_idx++; m_cnt = 0;
          if (m_idx == m_len) begin m_busy = 0; m_done = 1; end
        end else m_cnt++;
      end else if (dma_start) begin
        if (dma_len == 0) m_done = 1;
        else begin m_busy = 1; m_base = dma_base; m_len = dma_len; m_we = dma_we; m_idx = 0; m_cnt = 0; end
      end
      step();
    end
    idle_in(); step();
    for (int i = 0; i < 32; i++) begin
      nvec++; if (mem[i] !== ref_mem[i]) begin nerr++; $display("FAIL rand_mem[%0d] got=%h want=%h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_core();
    test_dma_write();
    test_starve();
    test_len0();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
